// File: rtl/ram32x4_pkg.sv
// ram32x4_pkg: constants shared by the RAM access controller and its arbiter.
//   ST_CLEAR / ST_SERVE : controller state encoding
//   PORT_A / PORT_B     : requester ids carried through the read-tracking pipe
//   RAM_AW/RAM_DW/RAM_DEPTH : geometry of the ram32x4 macro
package ram32x4_pkg;

  localparam int RAM_AW    = 5;
  localparam int RAM_DW    = 4;
  localparam int RAM_DEPTH = 32;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/ram32x4_access_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, rst             : clock, asynchronous active-high reset
//   i_en                 : grants allowed this cycle
//   i_a_valid, i_b_valid : requests
//   o_grant_a, o_grant_b : combinational grants (at most one high)
// The pointer names the port that wins a tie and flips to the other
// port after every grant.
module rr_arbiter2
  import ram32x4_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_a_valid,
  input  logic i_b_valid,
  output logic o_grant_a,
  output logic o_grant_b
);

  logic r_ptr;

  assign o_grant_a = i_en & i_a_valid & (~i_b_valid | (r_ptr == PORT_A));
  assign o_grant_b = i_en & i_b_valid & (~i_a_valid | (r_ptr == PORT_B));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= PORT_A;
    end else if (o_grant_a) begin
      r_ptr <= PORT_B;
    end else if (o_grant_b) begin
      r_ptr <= PORT_A;
    end
  end

endmodule

// File: rtl/ram32x4_access_ctrl.sv
// ram32x4_access_ctrl: shares one synchronous single-port 32x4 RAM between
// requesters A and B, with a clear sequencer that fills every word.
//   clock, reset           : rising-edge clock, asynchronous active-high reset
//   clear_req, fill_data   : start a clear (in SERVE) / value written by it
//   busy                   : high while clearing
//   a_req_* / b_req_*      : valid/ready request channels (we, addr, data)
//   a_rsp_* / b_rsp_*      : one-cycle read-data strobes
//   ram_address/data/wren  : registered drive to the RAM macro; ram_q back
module ram32x4_access_ctrl
  import ram32x4_pkg::*;
#(
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int DEPTH          = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  input  logic [RAM_DW-1:0] fill_data,
  output logic              busy,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [RAM_AW-1:0] a_req_addr,
  input  logic [RAM_DW-1:0] a_req_data,
  output logic              a_rsp_valid,
  output logic [RAM_DW-1:0] a_rsp_data,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [RAM_AW-1:0] b_req_addr,
  input  logic [RAM_DW-1:0] b_req_data,
  output logic              b_rsp_valid,
  output logic [RAM_DW-1:0] b_rsp_data,
  output logic [RAM_AW-1:0] ram_address,
  output logic [RAM_DW-1:0] ram_data,
  output logic              ram_wren,
  input  logic [RAM_DW-1:0] ram_q
);

  localparam state_t            ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_SERVE;
  localparam logic [RAM_AW-1:0] LAST    = RAM_AW'(DEPTH - 1);

  state_t            r_state;
  logic [RAM_AW-1:0] r_cnt;
  logic              w_serve;
  logic              w_grant_a;
  logic              w_grant_b;
  // Read issued in the current RAM-drive cycle, and its owner.
  logic              r_rd;
  logic              r_rd_port;
  // Read tag travelling alongside the RAM latency; last stage lines up with q.
  logic [RD_LAT:0]   r_trk_vld;
  logic [RD_LAT:0]   r_trk_port;

  assign w_serve     = (r_state == ST_SERVE);
  assign busy        = (r_state == ST_CLEAR);
  assign a_req_ready = w_grant_a;
  assign b_req_ready = w_grant_b;

  rr_arbiter2 u_arb (
    .clk       (clock),
    .rst       (reset),
    .i_en      (w_serve),
    .i_a_valid (a_req_valid),
    .i_b_valid (b_req_valid),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  // State, clear counter and registered RAM drive
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      r_rd        <= 1'b0;
      r_rd_port   <= PORT_A;
    end else begin
      ram_wren <= 1'b0;
      r_rd     <= 1'b0;
      if (r_state == ST_CLEAR) begin
        ram_address <= r_cnt;
        ram_data    <= fill_data;
        ram_wren    <= 1'b1;
        r_cnt       <= r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          r_state <= ST_SERVE;
        end
      end else begin
        // A request granted on the same edge as clear_req is still issued;
        // the clear writes start on the following edge, after it.
        if (clear_req) begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
        end
        if (w_grant_a) begin
          ram_address <= a_req_addr;
          ram_data    <= a_req_data;
          ram_wren    <= a_req_we;
          r_rd        <= ~a_req_we;
          r_rd_port   <= PORT_A;
        end else if (w_grant_b) begin
          ram_address <= b_req_addr;
          ram_data    <= b_req_data;
          ram_wren    <= b_req_we;
          r_rd        <= ~b_req_we;
          r_rd_port   <= PORT_B;
        end
      end
    end
  end

  // Read-tracking pipeline: one stage per clock from RAM sample to q valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_trk_vld  <= '0;
      r_trk_port <= '0;
    end else begin
      r_trk_vld[0]  <= r_rd;
      r_trk_port[0] <= r_rd_port;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_trk_vld[i]  <= r_trk_vld[i-1];
        r_trk_port[i] <= r_trk_port[i-1];
      end
    end
  end

  // Response registers: capture q into the owning port, hold otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_data  <= '0;
      b_rsp_data  <= '0;
    end else begin
      a_rsp_valid <= r_trk_vld[RD_LAT] & (r_trk_port[RD_LAT] == PORT_A);
      b_rsp_valid <= r_trk_vld[RD_LAT] & (r_trk_port[RD_LAT] == PORT_B);
      if (r_trk_vld[RD_LAT] && r_trk_port[RD_LAT] == PORT_A) begin
        a_rsp_data <= ram_q;
      end
      if (r_trk_vld[RD_LAT] && r_trk_port[RD_LAT] == PORT_B) begin
        b_rsp_data <= ram_q;
      end
    end
  end

endmodule

// File: doc/ram32x4_access_ctrl.md
Name: ram32x4_access_ctrl

Overview:
Controller that shares one synchronous single-port 32x4 RAM (ram32x4 macro: registered address/data/wren, q one clock later) between two requesters, A and B.
- Arbitrates round-robin and issues at most one access per clock.
- Returns read data through per-port response strobes.
- Runs a clear sequencer that writes a fill value to all 32 words after reset or on request.
- Sits between the switch/key front end or a test FSM and the RAM macro.

Parameters:
RD_LAT, 1, RAM read latency in clocks from address-sample edge to valid q (1 for ram32x4).
CLEAR_ON_RESET, 1, 1 = start a full clear when reset deasserts; 0 = go straight to SERVE.
DEPTH, 32, word count; address width is 5 (fixed for 32).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
clear_req  in  1  level; sampled each clock in SERVE, starts a clear
fill_data  in  4  value written by the clear sequencer; sampled per clear write
busy  out  1  high while clearing
a_req_valid  in  1  port A request
a_req_ready  out  1  port A accept
a_req_we  in  1  1 = write, 0 = read
a_req_addr  in  5  word address
a_req_data  in  4  write data
a_rsp_valid  out  1  one-cycle read-data strobe
a_rsp_data  out  4  read data, valid with a_rsp_valid
b_*  same set as port A, for port B
ram_address  out  5  to ram32x4 address
ram_data  out  4  to ram32x4 data
ram_wren  out  1  to ram32x4 wren
ram_q  in  4  from ram32x4 q

Behaviour:
- Reset values:
  - a/b_req_ready = 0, a/b_rsp_valid = 0, a/b_rsp_data = 0.
  - ram_address = 0, ram_data = 0, ram_wren = 0.
  - Round-robin pointer = A; clear counter = 0; read-tracking pipeline empty.
  - busy = CLEAR_ON_RESET.
- States:
  - CLEAR: first state after reset when CLEAR_ON_RESET = 1.
    - One write per clock: address = counter, data = fill_data, counter 0..31.
    - After address 31 is issued, go to SERVE; 32 clocks total.
    - busy = 1 and both readies = 0 throughout.
  - SERVE:
    - clear_req = 1 at an edge → CLEAR on that edge, counter reset to 0.
    - Requests handshaken on that same edge are still issued; no request is lost.
    - clear_req while in CLEAR is ignored.
- Handshake:
  - Transfer occurs at an edge where valid & ready.
  - Ready is combinational from state, both valids and the pointer:
    - a_req_ready = SERVE & a_req_valid & (!b_req_valid | ptr==A); B is symmetric.
    - Ready is never high without its own valid.
  - Requester holds addr/we/data stable while valid is high and ready is low.
- Arbitration:
  - Only one port valid → that port granted.
  - Both valid → port named by ptr is granted.
  - After any grant, ptr = the other port.
  - Guarantees no starvation: a held request is served within 2 clocks.
- RAM drive:
  - ram_* are registered.
  - Accept at edge t → ram_address/ram_data/ram_wren driven from t until the next edge; RAM samples at edge t+1.
  - ram_wren = 0 in cycles with no access.
- Read response:
  - ram_q valid after edge t+1+RD_LAT.
  - The controller registers it into the owning port's rsp_data, with rsp_valid high for exactly one clock starting at edge t+2+RD_LAT (t+3 for RD_LAT = 1).
  - The port is tracked in a shift register of depth RD_LAT+1.
  - Writes produce no response.
  - Responses are in issue order; back-to-back reads yield back-to-back strobes.
  - rsp_data holds its last value when rsp_valid = 0.
- Ordering:
  - Accesses execute in accept order.
  - A read accepted after a write to the same address returns the new data, including the very next clock.
  - Reads accepted before a clear return the pre-clear data.
  - Reads in flight when a clear starts still complete.
- Reset mid-operation (async): all outputs go to reset values immediately, in-flight responses are discarded, and the clear restarts at address 0 if CLEAR_ON_RESET.

Decomposition:
- Shared package ram32x4_pkg:
  - state encoding constants (ST_CLEAR, ST_SERVE)
  - port id constants (PORT_A = 0, PORT_B = 1)
  - RAM_AW = 5, RAM_DW = 4, RAM_DEPTH = 32
- One natural sub-module: rr_arbiter2 (2-way round-robin, combinational grant plus registered pointer).

Test Plan:
1. Reset with CLEAR_ON_RESET=1, fill_data=4'hA → busy high 32 clocks; ram_wren pulses with addresses 0..31 data A; then reads of addr 0, 17, 31 return A.
2. A writes addr 5 = 4'h3, next clock A reads addr 5 → a_rsp_valid exactly 3 clocks after the read accept, a_rsp_data = 3.
3. A and B hold reads (addr 1, 2) simultaneously after reset → A accepted first, B next clock; strobes on consecutive clocks in A, B order; b_rsp_valid never asserts for A's data.
4. clear_req asserted with fill_data=4'h0 while B read of addr 9 (value 7) is in flight → B receives 7; readies low 32 clocks; a later read of 9 returns 0.
5. Async reset asserted one clock after a read accept → rsp_valid stays 0, no stale strobe after reset release; clear restarts at address 0.
6. A holds valid continuously while B issues 4 requests → grants alternate A, B, A, B; no port waits more than 2 clocks.
